// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one command at a time to the ALU units and returns the selected unit's result
module alu_op_sequencer #(
   parameter int WIDTH_A         = 8,
   parameter int WIDTH_B         = 8,
   parameter int OUT_WIDTH       = 16,
   parameter int WIDTH_SHIFT_OUT = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       CMD_VALID,
   output logic                       CMD_READY,
   input  logic [3:0]                 CMD_FUN,
   input  logic [WIDTH_A-1:0]         CMD_A,
   input  logic [WIDTH_B-1:0]         CMD_B,
   output logic [WIDTH_A-1:0]         A,
   output logic [WIDTH_B-1:0]         B,
   output logic [1:0]                 ALU_FUN,
   output logic                       Arith_Enable,
   output logic                       Logic_Enable,
   output logic                       CMP_Enable,
   output logic                       Shift_Enable,
   input  logic [OUT_WIDTH-1:0]       ARITH_OUT,
   input  logic [OUT_WIDTH-1:0]       LOGIC_OUT,
   input  logic [OUT_WIDTH-1:0]       CMP_OUT,
   input  logic [WIDTH_SHIFT_OUT-1:0] SHIFT_OUT,
   output logic [OUT_WIDTH-1:0]       RES_DATA,
   output logic                       RES_VALID,
   input  logic                       RES_READY,
   output logic                       BUSY
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3;
   logic [1:0] state, unit_sel;
   logic [OUT_WIDTH-1:0] unit_res;
   always_comb unit_res = unit_sel == 2'd0 ? ARITH_OUT :
                          unit_sel == 2'd1 ? LOGIC_OUT :
                          unit_sel == 2'd2 ? CMP_OUT : OUT_WIDTH'(SHIFT_OUT);
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         unit_sel <= '0;
         A        <= '0;
         B        <= '0;
         ALU_FUN  <= '0;
         RES_DATA <= '0;
      end else begin
         if (state == IDLE && CMD_VALID) begin
            A        <= CMD_A;
            B        <= CMD_B;
            ALU_FUN  <= CMD_FUN[1:0];
            unit_sel <= CMD_FUN[3:2];
         end
         if (state == CAPTURE) RES_DATA <= unit_res;
         state <= state == IDLE    ? (CMD_VALID ? ISSUE : IDLE) :
                  state == ISSUE   ? CAPTURE :
                  state == CAPTURE ? RESP : (RES_READY ? IDLE : RESP);
      end
   end
   // ready is masked by reset so it only rises once RST is released
   assign CMD_READY    = RST && state == IDLE;
   assign BUSY         = state != IDLE;
   assign RES_VALID    = state == RESP;
   assign Arith_Enable = state == ISSUE && unit_sel == 2'd0;
   assign Logic_Enable = state == ISSUE && unit_sel == 2'd1;
   assign CMP_Enable   = state == ISSUE && unit_sel == 2'd2;
   assign Shift_Enable = state == ISSUE && unit_sel == 2'd3;
endmodule
